// File: rtl/cpu_run_sequencer.sv
// Run controller for the 3-bit-PC / 7x15-SRAM CPU core: owns the SRAM write port
// while a program is loaded, then gates PC_en for free-run, single-step and halt.
module cpu_run_sequencer #(
  parameter int          DEPTH   = 7,
  parameter int          ADDR_W  = 3,
  parameter int          DATA_W  = 15,
  parameter logic [3:0]  HALT_OP = 4'b1111,
  parameter logic [7:0]  MAX_CYC = 8'd200
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  input  logic              start_i,
  input  logic              step_mode_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_wa_o,
  output logic [DATA_W-1:0] sram_wd_o,
  output logic              pc_en_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] halt_pc_o,
  output logic [7:0]        cyc_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_RUN, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                pc_en_q, pc_en_d;
  logic [7:0]          cyc_q, cyc_d;
  logic                timeout_q, timeout_d;
  logic [ADDR_W-1:0]   halt_pc_q, halt_pc_d;
  logic                step_q;

  logic                accept;
  logic                stepEdge;
  logic                haltDec;
  logic                budgetHit;
  logic [7:0]          cycInc;
  logic                unusedInstrBits;

  assign load_ready_o    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept          = load_valid_i & load_ready_o;
  assign stepEdge        = step_i & ~step_q;
  assign haltDec         = (instr_i[DATA_W-1:DATA_W-4] == HALT_OP);
  assign cycInc          = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;
  assign budgetHit       = (cycInc == MAX_CYC);
  assign unusedInstrBits = ^instr_i[DATA_W-5:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      pc_en_q   <= 1'b0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
      halt_pc_q <= '0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      pc_en_q   <= pc_en_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
      halt_pc_q <= halt_pc_d;
      step_q    <= step_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    pc_en_d   = 1'b0;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    halt_pc_d = halt_pc_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          we_d = 1'b1;
          wa_d = wptr_q;
          wd_d = load_data_i;
          if (load_last_i || (wptr_q == ADDR_W'(DEPTH - 1))) begin
            state_d = S_ARMED;
            wptr_d  = '0;
          end else begin
            state_d = S_LOAD;
            wptr_d  = wptr_q + 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (start_i) begin
          state_d   = S_RUN;
          cyc_d     = '0;
          timeout_d = 1'b0;
          halt_pc_d = '0;
          pc_en_d   = ~step_mode_i;
        end
      end
      S_RUN: begin
        pc_en_d = step_mode_i ? stepEdge : 1'b1;
        // Halt and budget are only judged on cycles where the core really advanced.
        if (pc_en_q) begin
          cyc_d = cycInc;
          if (haltDec) halt_pc_d = pc_i;
          if (haltDec || budgetHit) begin
            pc_en_d   = 1'b0;
            timeout_d = budgetHit;
            state_d   = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (start_i)           state_d = S_ARMED;
        else if (load_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sram_we_o = we_q;
  assign sram_wa_o = wa_q;
  assign sram_wd_o = wd_q;
  assign pc_en_o   = pc_en_q;
  assign busy_o    = (state_q == S_LOAD) || (state_q == S_RUN);
  assign halted_o  = (state_q == S_HALT);
  assign timeout_o = timeout_q;
  assign halt_pc_o = halt_pc_q;
  assign cyc_cnt_o = cyc_q;

endmodule
